key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels.
REQ-002 Parameter DB_CYCLES, default 1000000, consecutive stable clocks required to accept a level change (20 ms at 50 MHz); legal range 1..2^24.
REQ-003 Parameter KEY_ACTIVE_LOW, default 1; when 1, a raw low level on KEY_IN means pressed.
REQ-004 CLK  input  1  system clock, 50 MHz board clock, rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 KEY_IN  input  N_KEYS  raw, asynchronous push-button/switch levels.
REQ-007 KEY_LVL  output  N_KEYS  debounced level, 1 = pressed, registered; drives downstream CLRN/LDN/ENP/ENT (inverted where active-low).
REQ-008 KEY_PRESS  output  N_KEYS  one-CLK pulse per accepted press (see REQ-020).

Function
REQ-009 Each KEY_IN bit SHALL pass through a two-flop synchronizer; the polarity-normalised output of the second flop is S[i] (1 = pressed).
REQ-010 Per channel, a counter CNT[i] of width clog2(DB_CYCLES+1) SHALL clear on any clock where S[i] == KEY_LVL[i].
REQ-011 On a clock where S[i] != KEY_LVL[i] and CNT[i] < DB_CYCLES-1, CNT[i] SHALL increment by 1.
REQ-012 On a clock where S[i] != KEY_LVL[i] and CNT[i] == DB_CYCLES-1, KEY_LVL[i] SHALL take S[i] and CNT[i] SHALL clear.
REQ-013 CNT[i] SHALL never wrap or exceed DB_CYCLES-1.
REQ-014 Latency: a clean raw transition SHALL appear on KEY_LVL exactly DB_CYCLES+2 clock edges after the first edge sampling the new raw level.
REQ-015 Any bounce that returns S[i] to KEY_LVL[i] before DB_CYCLES consecutive differing clocks SHALL leave KEY_LVL[i] unchanged and restart the count.
REQ-016 DB_CYCLES == 1 SHALL accept a change on the first differing clock (synchronizer-only behaviour).
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL each be handled per REQ-010..012 in the same cycles.
REQ-018 Per channel, a 1-bit state register IDLE/PENDING SHALL be maintained: IDLE when CNT==0, PENDING otherwise; observable for verification only.

Reset
REQ-019 While RST is high: synchronizer flops SHALL hold the released raw level (1 if KEY_ACTIVE_LOW, else 0), CNT SHALL be 0, KEY_LVL SHALL be 0, KEY_PRESS SHALL be 0; after RST is deasserted, a key held down through reset SHALL be accepted after DB_CYCLES+2 edges, like a fresh press.

Configuration
REQ-020 With macro KEY_DEBOUNCE_PRESS_PULSE_EN defined, KEY_PRESS[i] SHALL be high for exactly one CLK, registered, in the same cycle KEY_LVL[i] rises 0->1, and SHALL not pulse on release.
REQ-021 Without KEY_DEBOUNCE_PRESS_PULSE_EN, KEY_PRESS SHALL be tied to constant 0 and no edge-detect flops SHALL be generated.

Structure
REQ-022 Shared package key_pkg SHALL hold CLK_HZ (50000000), DEBOUNCE_MS (20), the derived default DB_CYCLES, and the IDLE/PENDING state encoding.
REQ-023 One sub-module key_db_cell (single-channel synchronizer, counter, and level/pulse registers) SHALL be instantiated N_KEYS times by a generate loop.

Verification (bench uses DB_CYCLES=8, N_KEYS=4, KEY_ACTIVE_LOW=1)
REQ-024 Clean press: KEY_IN[0] 1->0 held 20 clocks -> KEY_LVL[0] rises at edge 10 after the change; KEY_PRESS[0] is high for that single cycle only.
REQ-025 Bounce: KEY_IN[1] toggles low 5, high 2, low 5, high 3 clocks -> KEY_LVL[1] stays 0 and KEY_PRESS[1] stays 0 throughout.
REQ-026 Release: KEY_IN[0] 0->1 after acceptance -> KEY_LVL[0] falls 10 edges later; KEY_PRESS[0] stays 0.
REQ-027 Simultaneous: KEY_IN[3:0] = 4'b0000 at the same edge -> all four KEY_LVL bits rise on the same cycle, with four coincident KEY_PRESS pulses.
REQ-028 Reset mid-count: RST pulsed when CNT[2]=5 with KEY_IN[2] low -> KEY_LVL[2]=0 and CNT=0 immediately; key still held -> accepted 10 edges after RST falls.
REQ-029 Macro off: rerun the REQ-024 stimulus -> KEY_LVL identical, KEY_PRESS constant 4'b0000.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared timing constants and per-channel debounce state encoding.
package key_pkg;
  localparam int CLK_HZ = 50000000;
  localparam int DEBOUNCE_MS = 20;
  localparam int DB_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} db_state_t;
endpackage

// File: rtl/key_db_cell.sv
// key_db_cell: one key channel, two-flop synchronizer, stability counter, level and press registers.
// Press pulse flop exists only with KEY_DEBOUNCE_PRESS_PULSE_EN defined.
module key_db_cell
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_in,
  output logic lvl,
  output logic press
);
  localparam int W = $clog2(DB_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DB_CYCLES - 1);
  logic [1:0] sync;
  logic [W-1:0] cnt, cnt_nx;
  db_state_t st;
  logic s, hit;
  assign s = sync[1] ^ KEY_ACTIVE_LOW;
  assign hit = (s != lvl) && (cnt == LAST);
  // IDLE means the counter is at zero, so the first differing clock loads 1
  assign cnt_nx = (s == lvl || hit) ? '0 : (st == IDLE ? W'(1) : cnt + 1'b1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync <= {2{KEY_ACTIVE_LOW}};
      cnt <= '0;
      st <= IDLE;
      lvl <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      cnt <= cnt_nx;
      st <= (cnt_nx == '0) ? IDLE : PENDING;
      lvl <= hit ? s : lvl;
    end
`ifdef KEY_DEBOUNCE_PRESS_PULSE_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) press <= 1'b0;
    else press <= hit & s;
`else
  assign press = 1'b0;
`endif
endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent debounced key channels with optional press pulses.
// Press pulses are enabled by defining KEY_DEBOUNCE_PRESS_PULSE_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LVL,
  output logic [N_KEYS-1:0] KEY_PRESS
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g
    key_db_cell #(.DB_CYCLES(DB_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u (
      .CLK(CLK),
      .RST(RST),
      .key_in(KEY_IN[i]),
      .lvl(KEY_LVL[i]),
      .press(KEY_PRESS[i])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table-driven check of key_debounce with DB_CYCLES=8, plus reset-mid-count sequence.
module tb_key_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_in = 4'b1111;
  logic [3:0] key_lvl, key_press;
  int checks = 0;
  int failures = 0;
`ifdef KEY_DEBOUNCE_PRESS_PULSE_EN
  localparam logic [3:0] PMASK = 4'b1111;
`else
  localparam logic [3:0] PMASK = 4'b0000;
`endif
  typedef struct {
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] press;
  } vec_t;
  vec_t tbl[128];
  int n = 0;

  key_debounce #(.N_KEYS(4), .DB_CYCLES(8), .KEY_ACTIVE_LOW(1'b1)) dut (
    .CLK(clk),
    .RST(rst),
    .KEY_IN(key_in),
    .KEY_LVL(key_lvl),
    .KEY_PRESS(key_press)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] k, input logic [3:0] l, input logic [3:0] p);
    tbl[n] = '{k, l, p & PMASK};
    n++;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] k, input logic [3:0] l, input logic [3:0] p);
    key_in = k;
    @(posedge clk);
    #1;
    chk({nm, "_lvl"}, 32'(key_lvl), 32'(l));
    chk({nm, "_press"}, 32'(key_press), 32'(p));
  endtask

  initial begin
    // clean press on key0: accepted 10 edges after change (row 9)
    for (int j = 0; j < 20; j++) add(4'b1110, j >= 9 ? 4'b0001 : 4'b0000, j == 9 ? 4'b0001 : 4'b0000);
    // release key0: falls 10 edges later, no pulse
    for (int j = 0; j < 12; j++) add(4'b1111, j >= 9 ? 4'b0000 : 4'b0001, 4'b0000);
    // bounce on key1: low 5, high 2, low 5, high 3, then quiet
    for (int j = 0; j < 20; j++) begin
      logic lo;
      lo = (j < 5) || (j >= 7 && j < 12);
      add({2'b11, ~lo, 1'b1}, 4'b0000, 4'b0000);
    end
    // key3 low for 7 raw clocks: one short of acceptance
    for (int j = 0; j < 12; j++) add(j < 7 ? 4'b0111 : 4'b1111, 4'b0000, 4'b0000);
    // key3 low for exactly 8 raw clocks: accepted at row 9, released at row 17
    for (int j = 0; j < 22; j++)
      add(j < 8 ? 4'b0111 : 4'b1111, (j >= 9 && j < 17) ? 4'b1000 : 4'b0000, j == 9 ? 4'b1000 : 4'b0000);
    // all four keys pressed at once
    for (int j = 0; j < 20; j++) add(4'b0000, j >= 9 ? 4'b1111 : 4'b0000, j == 9 ? 4'b1111 : 4'b0000);
    for (int j = 0; j < 12; j++) add(4'b1111, j >= 9 ? 4'b0000 : 4'b1111, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_lvl", 32'(key_lvl), 32'h0);
    chk("reset_press", 32'(key_press), 32'h0);
    chk("reset_cnt0", 32'(dut.g[0].u.cnt), 32'h0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_lvl", 32'(key_lvl), 32'h0);

    for (int r = 0; r < n; r++) step($sformatf("vec%0d", r), tbl[r].key, tbl[r].lvl, tbl[r].press);

    // reset while key2 is mid-count, key still held afterwards
    for (int j = 0; j < 7; j++) step($sformatf("rmc_pre%0d", j), 4'b1011, 4'b0000, 4'b0000);
    chk("rmc_cnt5", 32'(dut.g[2].u.cnt), 32'd5);
    chk("rmc_pending", 32'(dut.g[2].u.st), 32'(key_pkg::PENDING));
    #2 rst = 1'b1;
    #1;
    chk("rmc_lvl_in_reset", 32'(key_lvl), 32'h0);
    chk("rmc_cnt_in_reset", 32'(dut.g[2].u.cnt), 32'h0);
    chk("rmc_idle_in_reset", 32'(dut.g[2].u.st), 32'(key_pkg::IDLE));
    @(posedge clk);
    #3 rst = 1'b0;
    for (int j = 0; j < 10; j++)
      step($sformatf("rmc_post%0d", j), 4'b1011, j == 9 ? 4'b0100 : 4'b0000, j == 9 ? (4'b0100 & PMASK) : 4'b0000);
    step("rmc_hold", 4'b1011, 4'b0100, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
